// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues in-order imem word requests, buffers {pc, instr} for decode
// and redirects on taken branches, discarding wrong-path work. Define FETCH_PERF_EN for perf counters.
module fetch_unit #(
    parameter int                   CPU_WIDTH       = 32,
    parameter logic [CPU_WIDTH-1:0] RESET_PC        = 32'h0000_0000,
    parameter int                   FIFO_DEPTH      = 4,
    parameter int                   MAX_OUTSTANDING = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [CPU_WIDTH-1:0] imem_req_addr,
    input  logic                 imem_rsp_valid,
    input  logic [CPU_WIDTH-1:0] imem_rsp_data,
    input  logic                 branch_valid,
    input  logic [CPU_WIDTH-1:0] branch_pc,
    input  logic [CPU_WIDTH-1:0] branch_offset,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [CPU_WIDTH-1:0] instr,
    output logic [CPU_WIDTH-1:0] instr_pc,
    output logic                 redirect_misaligned
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]          perf_redirects,
    output logic [31:0]          perf_starve
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] MAXO_C  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CPU_WIDTH-1:0] WORD_C = CPU_WIDTH'(4);

    logic [CPU_WIDTH-1:0] r_fetch_pc;
    logic [CPU_WIDTH-1:0] r_resp_pc;
    logic [CNT_W-1:0]     r_outstanding;
    logic [CNT_W-1:0]     r_drop_cnt;
    logic [CNT_W-1:0]     r_count;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic                 r_misaligned;
    logic [CPU_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
    logic [CPU_WIDTH-1:0] r_mem_pc   [FIFO_DEPTH];

    logic                 w_req_fire;
    logic                 w_rsp_fire;
    logic                 w_drop;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic [CPU_WIDTH-1:0] w_target_raw;
    logic [CPU_WIDTH-1:0] w_target;

    // Credits cover both in-flight requests and buffered entries, so a response always has a slot.
    assign imem_req_valid = !rst && (r_outstanding < MAXO_C) && ((r_count + r_outstanding) < DEPTH_C);
    assign imem_req_addr  = r_fetch_pc;

    assign w_req_fire   = imem_req_valid && imem_req_ready;
    assign w_rsp_fire   = imem_rsp_valid;
    assign w_drop       = w_rsp_fire && (r_drop_cnt != '0);
    assign w_push       = w_rsp_fire && !w_drop && !branch_valid;
    assign w_pop        = instr_valid && instr_ready;
    assign w_full       = (r_count == DEPTH_C);
    assign w_target_raw = branch_pc + branch_offset;
    assign w_target     = {w_target_raw[CPU_WIDTH-1:2], 2'b00};

    assign instr_valid         = (r_count != '0);
    assign instr               = r_mem_data[r_rd_ptr];
    assign instr_pc            = r_mem_pc[r_rd_ptr];
    assign redirect_misaligned = r_misaligned;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= imem_rsp_data;
            r_mem_pc[r_wr_ptr]   <= r_resp_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_misaligned  <= 1'b0;
        end else begin
            r_outstanding <= r_outstanding + CNT_W'(w_req_fire) - CNT_W'(w_rsp_fire);
            r_misaligned  <= branch_valid && (w_target_raw[1:0] != 2'b00);
            if (branch_valid) begin
                // Everything still in flight after this edge belongs to the wrong path.
                r_fetch_pc <= w_target;
                r_resp_pc  <= w_target;
                r_drop_cnt <= r_outstanding + CNT_W'(w_req_fire) - CNT_W'(w_rsp_fire);
                r_count    <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + WORD_C;
                end
                if (w_drop) begin
                    r_drop_cnt <= r_drop_cnt - CNT_W'(1);
                end
                if (w_push) begin
                    r_wr_ptr  <= r_wr_ptr + PTR_W'(1);
                    r_resp_pc <= r_resp_pc + WORD_C;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(w_push && w_full && !w_pop));

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_redirects;
    logic [31:0] r_perf_starve;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_redirects <= '0;
            r_perf_starve    <= '0;
        end else begin
            if (branch_valid && (r_perf_redirects != 32'hFFFF_FFFF)) begin
                r_perf_redirects <= r_perf_redirects + 32'd1;
            end
            if (!instr_valid && instr_ready && (r_perf_starve != 32'hFFFF_FFFF)) begin
                r_perf_starve <= r_perf_starve + 32'd1;
            end
        end
    end

    assign perf_redirects = r_perf_redirects;
    assign perf_starve    = r_perf_starve;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with epoch-tagged requests, a PC-stream scoreboard
// checked every cycle on the falling edge, and directed scenarios with literal expectations.
module tb_fetch_unit;

    localparam int FIFO_DEPTH = 4;
    localparam int MAX_OUT    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        branch_valid = 1'b0;
    logic [31:0] branch_pc = 32'h0;
    logic [31:0] branch_offset = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_misaligned;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_redirects;
    logic [31:0] perf_starve;
`endif

    fetch_unit #(
        .CPU_WIDTH(32), .RESET_PC(32'h0), .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .branch_valid(branch_valid), .branch_pc(branch_pc), .branch_offset(branch_offset),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .redirect_misaligned(redirect_misaligned)
`ifdef FETCH_PERF_EN
        , .perf_redirects(perf_redirects), .perf_starve(perf_starve)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [31:0] fq[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          mem_lat = 1;
    logic [31:0] m_fetch_addr = 32'h0;
    logic        m_mis = 1'b0;
    logic [31:0] m_red = 32'h0;
    logic [31:0] m_starve = 32'h0;
    logic        m_req_valid, m_instr_valid, m_req_fire, m_pop, m_kept, m_rsp_v;
    logic [31:0] m_tgt, m_junk;
    mreq_t       m_ent, m_new;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: the decode stream is the addresses of kept responses, in order; a response is kept
    // only if its request was issued after the latest redirect and does not coincide with one.
    always @(negedge clk) begin
        m_req_valid   = !rst && (mem_q.size() < MAX_OUT) && ((fq.size() + mem_q.size()) < FIFO_DEPTH);
        m_instr_valid = (fq.size() != 0);
        check("req_valid", {31'b0, imem_req_valid}, {31'b0, m_req_valid});
        if (m_req_valid) check("req_addr", imem_req_addr, m_fetch_addr);
        check("instr_valid", {31'b0, instr_valid}, {31'b0, m_instr_valid});
        if (m_instr_valid) begin
            check("instr_pc", instr_pc, fq[0]);
            check("instr", instr, mem_word(fq[0]));
        end
        check("misaligned", {31'b0, redirect_misaligned}, {31'b0, m_mis});
`ifdef FETCH_PERF_EN
        check("perf_redirects", perf_redirects, m_red);
        check("perf_starve", perf_starve, m_starve);
`endif
        m_rsp_v        = !rst && (mem_q.size() != 0) && (mem_q[0].due <= cyc);
        imem_rsp_valid = m_rsp_v;
        imem_rsp_data  = m_rsp_v ? mem_word(mem_q[0].addr) : 32'hDEAD_BEEF;
        m_req_fire     = m_req_valid && imem_req_ready;
        m_pop          = m_instr_valid && instr_ready;
        if (rst) begin
            mem_q.delete();
            fq.delete();
            m_fetch_addr = 32'h0;
            m_mis        = 1'b0;
            m_red        = 32'h0;
            m_starve     = 32'h0;
        end else begin
            if (!m_instr_valid && instr_ready && m_starve != 32'hFFFF_FFFF) m_starve = m_starve + 1;
            m_kept = 1'b0;
            if (m_rsp_v) begin
                m_ent  = mem_q.pop_front();
                m_kept = (m_ent.epoch == epoch) && !branch_valid;
            end
            if (m_pop) m_junk = fq.pop_front();
            if (m_kept) fq.push_back(m_ent.addr);
            if (m_req_fire) begin
                m_new.addr  = m_fetch_addr;
                m_new.epoch = epoch;
                m_new.due   = cyc + mem_lat;
                mem_q.push_back(m_new);
                m_fetch_addr = m_fetch_addr + 32'd4;
            end
            if (branch_valid) begin
                m_tgt        = branch_pc + branch_offset;
                m_mis        = (m_tgt[1:0] != 2'b00);
                m_fetch_addr = {m_tgt[31:2], 2'b00};
                fq.delete();
                epoch++;
                if (m_red != 32'hFFFF_FFFF) m_red = m_red + 1;
            end else begin
                m_mis = 1'b0;
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string nm, input int max_cyc);
        logic got;
        got = 1'b0;
        for (int i = 0; i < max_cyc && !got; i++) begin
            @(negedge clk);
            if (instr_valid) got = 1'b1;
            else step();
        end
        check({nm, "_timeout"}, {31'b0, got}, 32'd1);
    endtask

    task automatic branch(input logic [31:0] pc, input logic [31:0] off);
        branch_valid  = 1'b1;
        branch_pc     = pc;
        branch_offset = off;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        int fires;
        int gaps;

        repeat (3) step();
        @(negedge clk);
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_misaligned", {31'b0, redirect_misaligned}, 32'd0);
        step();
        rst = 1'b0;

        // Stream from reset with a 1-cycle memory
        @(negedge clk);
        check("t1_first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("t1_first_addr", imem_req_addr, 32'h0);
        step();
        step();
        @(negedge clk);
        check("t1_first_instr_valid", {31'b0, instr_valid}, 32'd1);
        check("t1_first_pc", instr_pc, 32'h0);
        step();
        @(negedge clk);
        check("t1_second_pc", instr_pc, 32'h4);
        step();
        gaps = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!instr_valid) gaps++;
            step();
        end
        check("t1_gaps", gaps, 0);

        // Decode stalled: credits cap requests at the buffer depth
        rst = 1'b1;
        instr_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        fires = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) fires++;
            step();
        end
        check("t2_req_count", fires, FIFO_DEPTH);
        @(negedge clk);
        check("t2_req_stalled", {31'b0, imem_req_valid}, 32'd0);
        step();
        instr_ready = 1'b1;
        fires = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) fires++;
            step();
        end
        check("t2_resume", {31'b0, fires != 0}, 32'd1);

        // Redirect with two requests in flight (3-cycle memory)
        rst = 1'b1;
        mem_lat = 3;
        step();
        step();
        rst = 1'b0;
        step();
        step();
        branch(32'h10, 32'hFFFF_FFF8);
        @(negedge clk);
        check("t3_two_inflight", {31'b0, imem_req_valid}, 32'd0);
        step();
        branch_valid = 1'b0;
        @(negedge clk);
        check("t3_flushed", {31'b0, instr_valid}, 32'd0);
        step();
        wait_valid("t3_wait", 20);
        check("t3_first_pc", instr_pc, 32'h8);
        step();

        // Redirect coincident with a request and a response
        rst = 1'b1;
        mem_lat = 1;
        step();
        step();
        rst = 1'b0;
        repeat (6) step();
        branch(32'h40, 32'h20);
        @(negedge clk);
        check("t4_req_fire", {31'b0, imem_req_valid}, 32'd1);
        check("t4_streaming", {31'b0, instr_valid}, 32'd1);
        step();
        branch_valid = 1'b0;
        @(negedge clk);
        check("t4_flushed", {31'b0, instr_valid}, 32'd0);
        step();
        wait_valid("t4_wait", 20);
        check("t4_first_pc", instr_pc, 32'h60);
        step();

        // Misaligned target
        repeat (4) step();
        branch(32'h100, 32'h6);
        step();
        branch_valid = 1'b0;
        @(negedge clk);
        check("t5_pulse", {31'b0, redirect_misaligned}, 32'd1);
        check("t5_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("t5_addr", imem_req_addr, 32'h104);
        step();
        @(negedge clk);
        check("t5_pulse_end", {31'b0, redirect_misaligned}, 32'd0);
        step();

        // Back-to-back redirects: the later one wins
        branch(32'h200, 32'h0);
        step();
        branch(32'h300, 32'h0);
        step();
        branch_valid = 1'b0;
        wait_valid("t6_wait", 20);
        check("t6_last_wins", instr_pc, 32'h300);
        step();

        // PC wraps past the top of the address space
        branch(32'hFFFF_FFF0, 32'h8);
        step();
        branch_valid = 1'b0;
        wait_valid("t7_wait", 20);
        check("t7_pc0", instr_pc, 32'hFFFF_FFF8);
        step();
        @(negedge clk);
        check("t7_pc1", instr_pc, 32'hFFFF_FFFC);
        step();
        @(negedge clk);
        check("t7_pc2", instr_pc, 32'h0);
        step();

        // Mixed traffic with back-pressure and sporadic redirects, checked by the model each cycle
        for (int r = 0; r < 2; r++) begin
            rst = 1'b1;
            mem_lat = 2 - r;
            step();
            rst = 1'b0;
            for (int i = 0; i < 150; i++) begin
                imem_req_ready = ($urandom_range(3) != 0);
                instr_ready    = ($urandom_range(2) != 0);
                branch_valid   = ($urandom_range(15) == 0);
                branch_pc      = $urandom & 32'h0000_FFFC;
                branch_offset  = 32'($urandom_range(64)) - 32'd32;
                step();
            end
            branch_valid   = 1'b0;
            imem_req_ready = 1'b1;
            instr_ready    = 1'b1;
            repeat (8) step();
        end

`ifdef FETCH_PERF_EN
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        check("t8_rst_redirects", perf_redirects, 32'd0);
        check("t8_rst_starve", perf_starve, 32'd0);
        step();
        rst = 1'b0;
        imem_req_ready = 1'b0;
        instr_ready = 1'b1;
        repeat (5) step();
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            branch(32'h20 * (i + 1), 32'h0);
            step();
            branch_valid = 1'b0;
            step();
        end
        @(negedge clk);
        check("t8_redirects", perf_redirects, 32'd3);
        check("t8_starve", perf_starve, 32'd5);
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        check("t8_clear_redirects", perf_redirects, 32'd0);
        check("t8_clear_starve", perf_starve, 32'd0);
        step();
        rst = 1'b0;
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
